// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package display_pkg;

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_W1   = 2'b01;
  localparam logic [1:0] MODE_W2   = 2'b10;
  localparam logic [1:0] MODE_W3   = 2'b11;

  localparam int unsigned BLANK_TICKS = 4;

endpackage

// File: rtl/refresh_prescaler.sv
// Digit-slot prescaler: counts 0..REFRESH_DIV-1, tick flags the last count.
module refresh_prescaler #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // tick is registered alongside cnt so it is high exactly while cnt is at its last value
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/word_display_scan_ctrl.sv
// Mode register, digit multiplexing, blank-on-change and blink for a
// four-digit active-low seven-segment display.
module word_display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode_in_i,
  input  logic       mode_load_i,
  output logic       mode_ready_o,
  output logic [1:0] mode_o,
  input  logic [6:0] seg_in3_i,
  input  logic [6:0] seg_in2_i,
  input  logic [6:0] seg_in1_i,
  input  logic [6:0] seg_in0_i,
  input  logic       blink_en_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o
);

  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [1:0]    BLANK_LAST = 2'(BLANK_TICKS - 1);

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    blank_cnt_q, blank_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          mode_ready_q, mode_ready_d;
  logic          tick;
  logic          clr_c;
  logic          show_c;
  logic [6:0]    seg_sel_c;

  refresh_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr_c),
    .tick_o(tick)
  );

  always_comb begin
    seg_sel_c = seg_in0_i;
    case (idx_q)
      2'd0:    seg_sel_c = seg_in0_i;
      2'd1:    seg_sel_c = seg_in1_i;
      2'd2:    seg_sel_c = seg_in2_i;
      default: seg_sel_c = seg_in3_i;
    endcase
  end

  // Display registers load the slot for idx_q on each tick; idx then advances.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    blank_cnt_d = blank_cnt_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    an_d        = an_q;
    seg_d       = seg_q;
    clr_c       = 1'b0;
    show_c      = 1'b0;

    case (state_q)
      SCAN: begin
        if (mode_load_i) begin
          state_d     = BLANK;
          mode_d      = mode_in_i;
          clr_c       = 1'b1;
          idx_d       = 2'd0;
          blank_cnt_d = 2'd0;
          an_d        = AN_OFF;
          seg_d       = SEG_OFF;
        end else if (tick) begin
          show_c = 1'b1;
          if (idx_q == 2'd3) begin
            if (frame_cnt_q == FRAME_LAST) begin
              frame_cnt_d = '0;
              phase_d     = ~phase_q;
            end else begin
              frame_cnt_d = frame_cnt_q + FW'(1);
            end
          end
        end
      end
      BLANK: begin
        if (tick) begin
          if (blank_cnt_q == BLANK_LAST) begin
            state_d = SCAN;
            show_c  = 1'b1;
          end else begin
            blank_cnt_d = blank_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = SCAN;
    endcase

    if (show_c) begin
      idx_d = idx_q + 2'd1;
      if (blink_en_i && phase_q) begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
      end else begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_sel_c;
      end
    end

    mode_ready_d = (state_d == SCAN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SCAN;
      mode_q       <= MODE_IDLE;
      idx_q        <= 2'd0;
      blank_cnt_q  <= 2'd0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      mode_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      blank_cnt_q  <= blank_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      mode_ready_q <= mode_ready_d;
    end
  end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign mode_o       = mode_q;
  assign mode_ready_o = mode_ready_q;

endmodule

// File: tb/tb_word_display_scan_ctrl.sv
// Directed and randomized check of word_display_scan_ctrl against a slot-level model.
module tb_word_display_scan_ctrl;

  localparam int RD = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode_in = 2'b00;
  logic       mode_load = 1'b0;
  logic       blink_en = 1'b0;
  logic [6:0] s0 = 7'h08, s1 = 7'h04, s2 = 7'h02, s3 = 7'h01;
  logic       mode_ready;
  logic [1:0] mode;
  logic [6:0] seg;
  logic [3:0] an;

  int total = 0;
  int bad   = 0;

  // model state: words are counted in digit slots and whole cycles since a restart
  logic [1:0] m_mode;
  bit         m_blank;
  int         m_t, m_dig, m_f3;
  logic [3:0] e_an;
  logic [6:0] e_seg;

  word_display_scan_ctrl #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_in_i   (mode_in),
    .mode_load_i (mode_load),
    .mode_ready_o(mode_ready),
    .mode_o      (mode),
    .seg_in3_i   (s3),
    .seg_in2_i   (s2),
    .seg_in1_i   (s1),
    .seg_in0_i   (s0),
    .blink_en_i  (blink_en),
    .seg_o       (seg),
    .an_o        (an)
  );

  always #5 clk = ~clk;

  task automatic show_slot();
    logic [3:0] an_tab [4];
    logic [6:0] seg_tab [4];
    bit dark;
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{s0, s1, s2, s3};
    dark = blink_en && (((m_f3 / BF) % 2) == 1);
    e_an  = dark ? 4'hF  : an_tab[m_dig];
    e_seg = dark ? 7'h7F : seg_tab[m_dig];
    if (m_dig == 3) m_f3++;
    m_dig = (m_dig + 1) % 4;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_mode = 2'b00; m_blank = 0; m_t = 0; m_dig = 0; m_f3 = 0;
      e_an = 4'hF; e_seg = 7'h7F;
    end else if (!m_blank && mode_load) begin
      m_mode = mode_in; m_blank = 1; m_t = 0; m_dig = 0;
      e_an = 4'hF; e_seg = 7'h7F;
    end else begin
      m_t++;
      if ((m_t % RD) == 0 && (!m_blank || m_t == 4 * RD)) begin
        m_blank = 0;
        show_slot();
      end
    end
  endtask

  task automatic check();
    total++;
    assert (an === e_an) else begin
      bad++; $error("FAIL an t=%0t got=%b exp=%b", $time, an, e_an);
    end
    total++;
    assert (seg === e_seg) else begin
      bad++; $error("FAIL seg t=%0t got=%h exp=%h", $time, seg, e_seg);
    end
    total++;
    assert (mode === m_mode) else begin
      bad++; $error("FAIL mode t=%0t got=%b exp=%b", $time, mode, m_mode);
    end
    total++;
    assert (mode_ready === !m_blank) else begin
      bad++; $error("FAIL mode_ready t=%0t got=%b exp=%b", $time, mode_ready, !m_blank);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_load(input logic [1:0] m);
    mode_in = m; mode_load = 1'b1;
    step();
    mode_load = 1'b0;
  endtask

  initial begin
    // reset and plain scan with fixed words
    run(2);
    rst_n = 1'b1;
    run(40);

    // load mid-scan while the next digit is 2, then a load during BLANK
    for (int k = 0; k < 8 && m_dig != 2; k++) step();
    pulse_load(2'b10);
    run(6);
    pulse_load(2'b11);
    run(24);

    // blink on then off
    blink_en = 1'b1;
    run(100);
    blink_en = 1'b0;
    run(40);

    // load on the prescaler's last count
    for (int k = 0; k < 8 && (m_t % RD) != RD - 1; k++) step();
    pulse_load(2'b01);
    run(24);

    // randomized loads, words and blink enable
    for (int i = 0; i < 500; i++) begin
      if ((i % 13) == 0) begin
        s0 = 7'($urandom); s1 = 7'($urandom); s2 = 7'($urandom); s3 = 7'($urandom);
      end
      if ($urandom_range(0, 59) == 0) blink_en = ~blink_en;
      mode_in   = 2'($urandom);
      mode_load = ($urandom_range(0, 24) == 0);
      step();
    end
    mode_load = 1'b0;

    // reset in the middle of BLANK
    for (int k = 0; k < 8 && m_blank; k++) step();
    pulse_load(2'b11);
    run(7);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
